lcd_char_controller: RTL and testbench
======================================

Name: lcd_char_controller

Overview:
- Peripheral-side controller for an HD44780-compatible character LCD on an 8-bit parallel bus.
- After reset, runs the LCD power-up and initialisation sequence, then asserts O_INIT_DONE.
- Accepts one character per I_WRITE_START/O_WRITE_DONE handshake from a client FSM, for example a text or button-display sequencer.
- Generates RS/RW/E/DB timing toward the LCD pins.

Parameters:
- POWERUP_CYCLES, 750000: idle cycles after reset before the first command (15 ms at 50 MHz).
- ENABLE_CYCLES, 25: E high width in cycles (500 ns).
- CMD_WAIT_CYCLES, 2500: post-E settle for normal commands and data (50 us).
- CLEAR_WAIT_CYCLES, 82000: post-E settle for the clear-display command 0x01 (1.64 ms).

Ports:
- I_CLK  input  1  system clock
- I_RST_N  input  1  asynchronous active-low reset
- I_WRITE_START  input  1  single-cycle request to write I_DISPLAY_DATA as a character
- I_DISPLAY_DATA  input  8  ASCII character; sampled only on an accepted start
- O_INIT_DONE  output  1  high once initialisation completes; stays high until reset
- O_WRITE_DONE  output  1  one-cycle pulse when a character write has finished
- O_LCD_DATA  output  8  LCD DB[7:0]
- O_LCD_RS  output  1  0 = command, 1 = data
- O_LCD_RW  output  1  constant 0 (write-only)
- O_LCD_E  output  1  LCD enable strobe

Behaviour:
- Reset (async, I_RST_N=0): all outputs 0. FSM goes to POWERUP, timer loads POWERUP_CYCLES. Asserting reset mid-operation aborts immediately, drops E, and restarts initialisation on release.
- Bus cycle, shared by commands and data, uses a single down-counter timer sized for the largest parameter:
  - SETUP: 1 cycle. O_LCD_DATA and O_LCD_RS driven, E=0.
  - PULSE: ENABLE_CYCLES cycles with E=1. Data and RS held stable.
  - WAIT: CMD_WAIT_CYCLES cycles, or CLEAR_WAIT_CYCLES for 0x01, with E=0. Data and RS held.
- Init sequence, all RS=0: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06, in that order. After the WAIT of 0x06, O_INIT_DONE rises next cycle, FSM enters IDLE.
- IDLE: when I_WRITE_START=1, latch I_DISPLAY_DATA and set RS=1 on that edge, then run one bus cycle, then DONE.
- DONE: one cycle with O_WRITE_DONE=1, then IDLE.
- Write latency: sampling edge = cycle 0. SETUP is cycle 1, PULSE is cycles 2..ENABLE_CYCLES+1, WAIT follows, O_WRITE_DONE is high in cycle ENABLE_CYCLES+CMD_WAIT_CYCLES+2.
- I_WRITE_START is ignored in every state except IDLE, including before init and during DONE. No queuing.
- I_DISPLAY_DATA changes after acceptance do not affect the write in progress.
- O_LCD_DATA and O_LCD_RS keep their last values while in IDLE.
- O_INIT_DONE never deasserts except on reset.

Optional Feature:
- Macro LCD_LINE_WRAP_EN.
- Defined:
  - 5-bit column counter, reset 0, incremented after each data write, wraps 31->0. A wrapped flag is set on the 31->0 wrap.
  - On an accepted start with column==16, insert command 0xC0 (RS=0, full bus cycle) before the data cycle.
  - On an accepted start with column==0 and the wrapped flag set, insert 0x80 first and clear the flag.
  - O_WRITE_DONE pulses only after the data cycle. Latency grows by 1+ENABLE_CYCLES+CMD_WAIT_CYCLES.
- Undefined: no counter and no inserted commands; the LCD auto-increments its address natively.

Test Plan:
Bench uses POWERUP_CYCLES=10, ENABLE_CYCLES=2, CMD_WAIT_CYCLES=4, CLEAR_WAIT_CYCLES=8.
- Release reset, no starts -> six E pulses, each 2 cycles wide, carrying 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with RS=0. The 0x01 gap is 8 cycles. O_INIT_DONE rises one cycle after the last WAIT and remains 1. O_LCD_RW=0 throughout.
- After init, pulse start with data 0x48 at cycle 0 -> RS=1 and DB=0x48 in cycle 1, E=1 in cycles 2-3, O_WRITE_DONE=1 only in cycle 8.
- Pulse start with 0x45 during POWERUP, during an init command, and during the DONE cycle of a prior write -> no E pulse and no O_WRITE_DONE. Output sequences unchanged.
- Client sends "HELLO" (0x48, 0x45, 0x4C, 0x4C, 0x4F), each start issued the cycle after the previous O_WRITE_DONE -> five data E pulses in order, five O_WRITE_DONE pulses.
- Assert I_RST_N=0 while E=1 during a write -> E, RS, DB, O_INIT_DONE and O_WRITE_DONE all 0 immediately. On release, the full init sequence repeats.
- With LCD_LINE_WRAP_EN, write 33 chars -> 0xC0 command before the 17th char, 0x80 before the 33rd, 33 O_WRITE_DONE pulses.

Source files
------------

// File: rtl/lcd_char_controller_if.sv
// rtl/lcd_char_controller_if.sv - client-side character write handshake between sequencer and LCD controller
`timescale 1ns/1ps

interface lcd_char_controller_if;
  logic       I_WRITE_START;
  logic [7:0] I_DISPLAY_DATA;
  logic       O_INIT_DONE;
  logic       O_WRITE_DONE;

  modport master (
    output I_WRITE_START,
    output I_DISPLAY_DATA,
    input  O_INIT_DONE,
    input  O_WRITE_DONE
  );

  modport slave (
    input  I_WRITE_START,
    input  I_DISPLAY_DATA,
    output O_INIT_DONE,
    output O_WRITE_DONE
  );
endinterface

// File: rtl/lcd_char_controller.sv
// rtl/lcd_char_controller.sv - HD44780 8-bit bus controller: power-up init then one character per handshake
// Optional macro LCD_LINE_WRAP_EN: track column and insert 0xC0 / 0x80 address commands on line wrap.
`timescale 1ns/1ps

module lcd_char_controller #(
  parameter int POWERUP_CYCLES    = 750000,
  parameter int ENABLE_CYCLES     = 25,
  parameter int CMD_WAIT_CYCLES   = 2500,
  parameter int CLEAR_WAIT_CYCLES = 82000
) (
  input  logic                  I_CLK,
  input  logic                  I_RST_N,
  lcd_char_controller_if.slave  bus,
  output logic [7:0]            O_LCD_DATA,
  output logic                  O_LCD_RS,
  output logic                  O_LCD_RW,
  output logic                  O_LCD_E
);

  localparam int MAX_A      = (POWERUP_CYCLES > ENABLE_CYCLES) ? POWERUP_CYCLES : ENABLE_CYCLES;
  localparam int MAX_B      = (CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ? CMD_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
  localparam int MAX_CYCLES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW         = $clog2(MAX_CYCLES + 1);

  typedef logic [TW-1:0] timer_t;

  localparam timer_t T_POWERUP = timer_t'(POWERUP_CYCLES);
  localparam timer_t T_ENABLE  = timer_t'(ENABLE_CYCLES);
  localparam timer_t T_CMD     = timer_t'(CMD_WAIT_CYCLES);
  localparam timer_t T_CLEAR   = timer_t'(CLEAR_WAIT_CYCLES);
  localparam timer_t T_ONE     = timer_t'(1);

  typedef enum logic [2:0] {
    S_POWERUP,
    S_SETUP,
    S_PULSE,
    S_WAIT,
    S_IDLE,
    S_DONE
  } state_t;

  state_t     state_q;
  timer_t     timer_q;
  logic [7:0] data_q;
  logic       rs_q;
  logic       e_q;
  logic       init_done_q;
  logic       write_done_q;
  logic [2:0] cmd_idx_q;
`ifdef LCD_LINE_WRAP_EN
  logic [4:0] col_q;
  logic       wrapped_q;
  logic       pending_q;
  logic [7:0] char_q;
`endif

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_cmd = 8'h38;
      3'd3:             init_cmd = 8'h0C;
      3'd4:             init_cmd = 8'h01;
      3'd5:             init_cmd = 8'h06;
      default:          init_cmd = 8'h00;
    endcase
  endfunction

  // Every phase lasts the loaded count of cycles; leaving happens on the edge where timer_q is 1.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q      <= S_POWERUP;
      timer_q      <= T_POWERUP;
      data_q       <= 8'h00;
      rs_q         <= 1'b0;
      e_q          <= 1'b0;
      init_done_q  <= 1'b0;
      write_done_q <= 1'b0;
      cmd_idx_q    <= 3'd0;
`ifdef LCD_LINE_WRAP_EN
      col_q        <= 5'd0;
      wrapped_q    <= 1'b0;
      pending_q    <= 1'b0;
      char_q       <= 8'h00;
`endif
    end else begin
      write_done_q <= 1'b0;
      case (state_q)
        S_POWERUP: begin
          if (timer_q <= T_ONE) begin
            state_q   <= S_SETUP;
            data_q    <= init_cmd(3'd0);
            rs_q      <= 1'b0;
            cmd_idx_q <= 3'd0;
          end else begin
            timer_q <= timer_q - T_ONE;
          end
        end
        S_SETUP: begin
          state_q <= S_PULSE;
          e_q     <= 1'b1;
          timer_q <= T_ENABLE;
        end
        S_PULSE: begin
          if (timer_q <= T_ONE) begin
            state_q <= S_WAIT;
            e_q     <= 1'b0;
            timer_q <= (!rs_q && data_q == 8'h01) ? T_CLEAR : T_CMD;
          end else begin
            timer_q <= timer_q - T_ONE;
          end
        end
        S_WAIT: begin
          if (timer_q > T_ONE) begin
            timer_q <= timer_q - T_ONE;
          end else if (!init_done_q) begin
            if (cmd_idx_q == 3'd5) begin
              state_q     <= S_IDLE;
              init_done_q <= 1'b1;
            end else begin
              state_q   <= S_SETUP;
              cmd_idx_q <= cmd_idx_q + 3'd1;
              data_q    <= init_cmd(cmd_idx_q + 3'd1);
            end
`ifdef LCD_LINE_WRAP_EN
          end else if (pending_q) begin
            // Address command finished; now run the character itself.
            state_q   <= S_SETUP;
            pending_q <= 1'b0;
            data_q    <= char_q;
            rs_q      <= 1'b1;
          end else begin
            state_q      <= S_DONE;
            write_done_q <= 1'b1;
            col_q        <= col_q + 5'd1;
            if (col_q == 5'd31) wrapped_q <= 1'b1;
          end
`else
          end else begin
            state_q      <= S_DONE;
            write_done_q <= 1'b1;
          end
`endif
        end
        S_IDLE: begin
          if (bus.I_WRITE_START) begin
            state_q <= S_SETUP;
`ifdef LCD_LINE_WRAP_EN
            char_q  <= bus.I_DISPLAY_DATA;
            if (col_q == 5'd16) begin
              data_q    <= 8'hC0;
              rs_q      <= 1'b0;
              pending_q <= 1'b1;
            end else if (col_q == 5'd0 && wrapped_q) begin
              data_q    <= 8'h80;
              rs_q      <= 1'b0;
              pending_q <= 1'b1;
              wrapped_q <= 1'b0;
            end else begin
              data_q <= bus.I_DISPLAY_DATA;
              rs_q   <= 1'b1;
            end
`else
            data_q  <= bus.I_DISPLAY_DATA;
            rs_q    <= 1'b1;
`endif
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_POWERUP;
          timer_q <= T_POWERUP;
          e_q     <= 1'b0;
        end
      endcase
    end
  end

  assign O_LCD_DATA       = data_q;
  assign O_LCD_RS         = rs_q;
  assign O_LCD_RW         = 1'b0;
  assign O_LCD_E          = e_q;
  assign bus.O_INIT_DONE  = init_done_q;
  assign bus.O_WRITE_DONE = write_done_q;

endmodule

// File: tb/tb_lcd_char_controller.sv
// tb/tb_lcd_char_controller.sv - directed table-driven bench for lcd_char_controller
`timescale 1ns/1ps

module tb_lcd_char_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_char_controller_if bus();
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;

  lcd_char_controller #(
    .POWERUP_CYCLES   (10),
    .ENABLE_CYCLES    (2),
    .CMD_WAIT_CYCLES  (4),
    .CLEAR_WAIT_CYCLES(8)
  ) dut (
    .I_CLK     (clk),
    .I_RST_N   (rst_n),
    .bus       (bus),
    .O_LCD_DATA(lcd_data),
    .O_LCD_RS  (lcd_rs),
    .O_LCD_RW  (lcd_rw),
    .O_LCD_E   (lcd_e)
  );

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         rise;
    int         fall;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         width;
    int         gap;
  } init_rec_t;

  ev_t        ev_q[$];
  ev_t        ev_tmp;
  init_rec_t  init_tab[6];
  logic [7:0] hello[5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

  int   cyc = 0;
  int   done_cnt = 0;
  int   idone_cyc = -1;
  logic prev_e = 1'b0;
  logic prev_idone = 1'b0;
  logic [7:0] cur_data = 8'h00;
  logic cur_rs = 1'b0;
  int   cur_rise = 0;
  bit   rw_bad = 1'b0;
  bit   stable_bad = 1'b0;
  bit   idone_drop = 1'b0;

  int checks = 0;
  int errors = 0;

  // Pin monitor: every completed E pulse becomes one record.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (lcd_rw !== 1'b0) rw_bad = 1'b1;
    if (lcd_e && !prev_e) begin
      cur_data = lcd_data;
      cur_rs   = lcd_rs;
      cur_rise = cyc;
    end else if (lcd_e && (lcd_data !== cur_data || lcd_rs !== cur_rs)) begin
      stable_bad = 1'b1;
    end
    if (!lcd_e && prev_e) begin
      ev_tmp.data = cur_data;
      ev_tmp.rs   = cur_rs;
      ev_tmp.rise = cur_rise;
      ev_tmp.fall = cyc;
      ev_q.push_back(ev_tmp);
    end
    if (bus.O_WRITE_DONE) done_cnt = done_cnt + 1;
    if (bus.O_INIT_DONE && !prev_idone) idone_cyc = cyc;
    if (!bus.O_INIT_DONE && prev_idone && rst_n) idone_drop = 1'b1;
    prev_e     = lcd_e;
    prev_idone = bus.O_INIT_DONE;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       sig = bus.O_WRITE_DONE;
      1:       sig = lcd_e;
      default: sig = bus.O_INIT_DONE;
    endcase
  endfunction

  task automatic wait_for(input int which, input int limit, input string name);
    int  n = 0;
    logic seen;
    seen = sig(which);
    while (!seen && n < limit) begin
      @(negedge clk);
      n++;
      seen = sig(which);
    end
    chk(name, seen, 1);
  endtask

  task automatic release_reset(output int r);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    r = cyc;
  endtask

  task automatic write_char(input logic [7:0] c);
    @(negedge clk);
    bus.I_WRITE_START  = 1'b1;
    bus.I_DISPLAY_DATA = c;
    @(negedge clk);
    bus.I_WRITE_START  = 1'b0;
    bus.I_DISPLAY_DATA = 8'hFF;
    wait_for(0, 200, "write_done_timeout");
  endtask

  task automatic check_init(input int base, input int r);
    int n;
    n = ev_q.size() - base;
    chk("init_pulse_count", n, 6);
    if (n >= 6) begin
      chk("init_first_rise", ev_q[base].rise - r, 11);
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("init%0d_data", i), ev_q[base+i].data, init_tab[i].data);
        chk($sformatf("init%0d_rs", i), ev_q[base+i].rs, init_tab[i].rs);
        chk($sformatf("init%0d_width", i), ev_q[base+i].fall - ev_q[base+i].rise, init_tab[i].width);
        if (i < 5)
          chk($sformatf("init%0d_gap", i), ev_q[base+i+1].rise - ev_q[base+i].fall, init_tab[i].gap);
      end
      chk("init_done_latency", idone_cyc - ev_q[base+5].fall, 4);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int base;
    int d0;
    int s0;
    ev_t exp_q[$];
    ev_t e;

    // gap = WAIT length + 1 SETUP cycle between E fall and next E rise
    init_tab[0] = '{8'h38, 1'b0, 2, 5};
    init_tab[1] = '{8'h38, 1'b0, 2, 5};
    init_tab[2] = '{8'h38, 1'b0, 2, 5};
    init_tab[3] = '{8'h0C, 1'b0, 2, 5};
    init_tab[4] = '{8'h01, 1'b0, 2, 9};
    init_tab[5] = '{8'h06, 1'b0, 2, 0};

    bus.I_WRITE_START  = 1'b0;
    bus.I_DISPLAY_DATA = 8'h00;

    #1;
    chk("rst_e", lcd_e, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_data", lcd_data, 0);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_init_done", bus.O_INIT_DONE, 0);
    chk("rst_write_done", bus.O_WRITE_DONE, 0);

    @(negedge clk);
    release_reset(r);
    base = ev_q.size();
    wait_for(2, 400, "init_timeout");
    #1;
    check_init(base, r);
    chk("init_no_write_done", done_cnt, 0);

    // single write 0x48: latency from sampling edge
    @(negedge clk);
    bus.I_WRITE_START  = 1'b1;
    bus.I_DISPLAY_DATA = 8'h48;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.I_WRITE_START  = 1'b0;
        bus.I_DISPLAY_DATA = 8'h00;
        chk("wr_setup_rs", lcd_rs, 1);
        chk("wr_setup_data", lcd_data, 8'h48);
      end
      chk($sformatf("wr_e_c%0d", k), lcd_e, (k == 2 || k == 3));
      chk($sformatf("wr_done_c%0d", k), bus.O_WRITE_DONE, (k == 8));
      if (k == 3) chk("wr_data_held", lcd_data, 8'h48);
    end
    chk("idle_data_kept", lcd_data, 8'h48);
    chk("idle_rs_kept", lcd_rs, 1);

    // start during DONE is ignored
    write_char(8'h41);
    bus.I_WRITE_START  = 1'b1;
    bus.I_DISPLAY_DATA = 8'h45;
    #1;
    s0 = ev_q.size();
    d0 = done_cnt;
    @(negedge clk);
    bus.I_WRITE_START = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("done_start_no_pulse", ev_q.size() - s0, 0);
    chk("done_start_no_done", done_cnt - d0, 0);
    chk("done_start_data", lcd_data, 8'h41);

    // HELLO back-to-back
    base = ev_q.size();
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) write_char(hello[i]);
    #1;
    chk("hello_done_count", done_cnt - d0, 5);
    chk("hello_pulse_count", ev_q.size() - base, 5);
    if (ev_q.size() - base >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("hello%0d_data", i), ev_q[base+i].data, hello[i]);
        chk($sformatf("hello%0d_rs", i), ev_q[base+i].rs, 1);
        chk($sformatf("hello%0d_width", i), ev_q[base+i].fall - ev_q[base+i].rise, 2);
      end
    end

    // reset while E is high
    @(negedge clk);
    bus.I_WRITE_START  = 1'b1;
    bus.I_DISPLAY_DATA = 8'h5A;
    @(negedge clk);
    bus.I_WRITE_START = 1'b0;
    wait_for(1, 50, "mid_e_timeout");
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_e", lcd_e, 0);
    chk("abort_rs", lcd_rs, 0);
    chk("abort_data", lcd_data, 0);
    chk("abort_init_done", bus.O_INIT_DONE, 0);
    chk("abort_write_done", bus.O_WRITE_DONE, 0);
    repeat (3) @(negedge clk);
    release_reset(r);
    base = ev_q.size();
    d0 = done_cnt;

    // starts during POWERUP, during an init E pulse and during an init WAIT
    repeat (3) @(negedge clk);
    bus.I_WRITE_START  = 1'b1;
    bus.I_DISPLAY_DATA = 8'h45;
    @(negedge clk);
    bus.I_WRITE_START = 1'b0;
    wait_for(1, 50, "reinit_e_timeout");
    bus.I_WRITE_START = 1'b1;
    @(negedge clk);
    bus.I_WRITE_START = 1'b0;
    repeat (2) @(negedge clk);
    bus.I_WRITE_START = 1'b1;
    @(negedge clk);
    bus.I_WRITE_START = 1'b0;
    wait_for(2, 400, "reinit_timeout");
    #1;
    check_init(base, r);
    chk("reinit_no_write_done", done_cnt - d0, 0);

    // 33 characters: line wrap commands appear only with the optional feature
    exp_q.delete();
    for (int i = 1; i <= 33; i++) begin
`ifdef LCD_LINE_WRAP_EN
      if (i == 17) begin
        e.data = 8'hC0; e.rs = 1'b0; e.rise = 0; e.fall = 0;
        exp_q.push_back(e);
      end
      if (i == 33) begin
        e.data = 8'h80; e.rs = 1'b0; e.rise = 0; e.fall = 0;
        exp_q.push_back(e);
      end
`endif
      e.data = 8'h40 + 8'(i); e.rs = 1'b1; e.rise = 0; e.fall = 0;
      exp_q.push_back(e);
    end
    base = ev_q.size();
    d0 = done_cnt;
    for (int i = 1; i <= 33; i++) write_char(8'h40 + 8'(i));
    #1;
    chk("wrap_done_count", done_cnt - d0, 33);
    chk("wrap_pulse_count", ev_q.size() - base, exp_q.size());
    if (ev_q.size() - base == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        chk($sformatf("wrap%0d_data", i), ev_q[base+i].data, exp_q[i].data);
        chk($sformatf("wrap%0d_rs", i), ev_q[base+i].rs, exp_q[i].rs);
      end
    end

    chk("rw_always_zero", rw_bad, 0);
    chk("data_stable_during_e", stable_bad, 0);
    chk("init_done_never_dropped", idone_drop, 0);
    chk("final_init_done", bus.O_INIT_DONE, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
